// File: rtl/controle_servo_pkg.sv
// Shared constants and width decode for the servo PWM generator.
// - PERIODO : PWM frame length in clock cycles (20 ms at 50 MHz)
// - CNT_W   : frame counter width, 2**CNT_W must be >= PERIODO
// - LARG_*  : high-time in cycles for each posicao code (0.7 ms .. 2.2 ms)
// - largura_de(posicao, tab) : looks up the high-time for a position code
package controle_servo_pkg;

  localparam int unsigned PERIODO  = 1000000;
  localparam int unsigned CNT_W    = 20;

  localparam int unsigned LARG_000 = 35000;
  localparam int unsigned LARG_001 = 45700;
  localparam int unsigned LARG_010 = 56450;
  localparam int unsigned LARG_011 = 67150;
  localparam int unsigned LARG_100 = 77850;
  localparam int unsigned LARG_101 = 88550;
  localparam int unsigned LARG_110 = 99300;
  localparam int unsigned LARG_111 = 110000;

  // Entry [i] is the high-time for posicao == i.
  typedef logic [7:0][31:0] larg_tab_t;

  localparam larg_tab_t LARG_TAB = {
    32'(LARG_111), 32'(LARG_110), 32'(LARG_101), 32'(LARG_100),
    32'(LARG_011), 32'(LARG_010), 32'(LARG_001), 32'(LARG_000)
  };

  function automatic logic [31:0] largura_de(input logic [2:0] posicao, input larg_tab_t tab);
    return tab[posicao];
  endfunction

endpackage

// File: rtl/contador_m.sv
// Free-running modulo-M counter.
// - clock    : rising-edge clock
// - reset    : asynchronous, active-low reset (count returns to 0)
// - enable   : count advances only when high
// - contagem : current count, 0..M-1
// - fim      : high while contagem == M-1 (last cycle before wrap)
module contador_m #(
  parameter int unsigned M = 1000000,
  parameter int unsigned W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic [W-1:0] contagem,
  output logic         fim
);

  logic [W-1:0] cnt_q, cnt_d;

  assign fim      = (cnt_q == W'(M - 1));
  assign contagem = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = fim ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_servo_3.sv
// Hobby-servo PWM generator: one pulse per PERIODO-cycle frame whose high-time is
// selected by a 3-bit position code. A new code only takes effect at a frame
// boundary, so a running pulse is never cut short or stretched.
// - clock       : 50 MHz system clock, rising edge
// - reset       : asynchronous, active-low reset
// - posicao     : requested position code (000 = 0.7 ms .. 111 = 2.2 ms)
// - controle    : registered PWM output to the servo
// - db_controle : debug copy of controle, same cycle
// Optional build macro POSICAO_SYNC_EN: when defined, posicao is passed through a
// 2-flop synchronizer (reset 000) before decode; otherwise posicao must already be
// synchronous to clock.
module controle_servo_3 #(
  parameter int unsigned                   PERIODO  = controle_servo_pkg::PERIODO,
  parameter int unsigned                   CNT_W    = controle_servo_pkg::CNT_W,
  parameter controle_servo_pkg::larg_tab_t LARGURAS = controle_servo_pkg::LARG_TAB
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] posicao,
  output logic       controle,
  output logic       db_controle
);

  import controle_servo_pkg::*;

  logic [CNT_W-1:0] contador;
  logic             fim;
  logic [2:0]       posicao_dec;
  logic [CNT_W-1:0] largura_dec;
  logic [CNT_W-1:0] largura_q;
  logic             controle_q;

  contador_m #(
    .M (PERIODO),
    .W (CNT_W)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .enable   (1'b1),
    .contagem (contador),
    .fim      (fim)
  );

`ifdef POSICAO_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= posicao;
      sync2_q <= sync1_q;
    end
  end

  assign posicao_dec = sync2_q;
`else
  assign posicao_dec = posicao;
`endif

  assign largura_dec = CNT_W'(largura_de(posicao_dec, LARGURAS));

  // Width is latched on the last count of a frame, so the comparison sees a
  // stable value for the whole of the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      largura_q  <= CNT_W'(LARGURAS[0]);
      controle_q <= 1'b0;
    end else begin
      if (fim) begin
        largura_q <= largura_dec;
      end
      controle_q <= (contador < largura_q);
    end
  end

  assign controle    = controle_q;
  assign db_controle = controle_q;

endmodule

// File: tb/tb_controle_servo_3.sv
// Directed bench for controle_servo_3 using a shortened 200-cycle frame and a
// scaled width table so whole frames can be measured quickly.
module tb_controle_servo_3;

  localparam int unsigned P = 200;
  localparam controle_servo_pkg::larg_tab_t TAB = {
    32'd110, 32'd99, 32'd88, 32'd78, 32'd67, 32'd56, 32'd45, 32'd35
  };
  localparam int W_EXP [8] = '{35, 45, 56, 67, 78, 88, 99, 110};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] posicao = 3'b000;
  logic       controle;
  logic       db_controle;

  int errors = 0;
  int checks = 0;

  controle_servo_3 #(
    .PERIODO  (P),
    .CNT_W    (20),
    .LARGURAS (TAB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .posicao     (posicao),
    .controle    (controle),
    .db_controle (db_controle)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Debug output must mirror the PWM output on every cycle.
  always @(negedge clock) begin
    if (reset) check("db_mirror", 32'(db_controle), 32'(controle));
  end

  task automatic step();
    @(negedge clock);
  endtask

  // Starts on the first high sample of a pulse; ends on the first high sample
  // of the following pulse.
  task automatic measure(output int hi, output int per);
    hi = 0;
    while (controle === 1'b1 && hi < 2 * P) begin
      hi++;
      step();
    end
    per = hi;
    while (controle !== 1'b1 && per < 4 * P) begin
      per++;
      step();
    end
  endtask

  task automatic measure_chk(input string tag, input int exp_hi);
    int hi, per;
    measure(hi, per);
    check({tag, "_high"}, 32'(hi), 32'(exp_hi));
    check({tag, "_period"}, 32'(per), 32'(P));
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    int   n;
    n = 0;
    do begin
      prev = controle;
      step();
      n++;
    end while (!(prev === 1'b0 && controle === 1'b1) && n < 4 * P);
    if (n >= 4 * P) check({tag, "_rise_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int prev_p;

    // Reset state
    repeat (3) step();
    check("rst_controle", 32'(controle), 32'd0);
    check("rst_db", 32'(db_controle), 32'd0);

    // Release: output rises one cycle later, first frame uses width for 000
    reset = 1'b1;
    #1 check("release_low", 32'(controle), 32'd0);
    step();
    check("rise_after_release", 32'(controle), 32'd1);
    measure_chk("frame0", W_EXP[0]);

    // 000 -> 111 while the pulse is high: current pulse unchanged
    posicao = 3'd7;
    measure_chk("midpulse_old", W_EXP[0]);
    measure_chk("midpulse_new", W_EXP[7]);

    // Step through every code; each frame shows the code set at its start
    // only from the following frame.
    prev_p = 7;
    for (int p = 1; p < 8; p++) begin
      posicao = 3'(p);
      measure_chk($sformatf("step%0d", p), W_EXP[prev_p]);
      prev_p = p;
    end
    measure_chk("step_last", W_EXP[7]);

    // Asynchronous reset in the middle of a pulse
    repeat (5) step();
    #3 reset = 1'b0;
    #1;
    check("async_rst_controle", 32'(controle), 32'd0);
    check("async_rst_db", 32'(db_controle), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("rise_after_rst2", 32'(controle), 32'd1);
    measure_chk("after_rst", W_EXP[0]);
    measure_chk("after_rst_next", W_EXP[7]);

    // At the rise sample the counter holds 1; P-3 steps land in cycle P-2.
    repeat (P - 3) step();
    posicao = 3'd1;
    wait_rise("late2");
`ifdef POSICAO_SYNC_EN
    measure_chk("late2", W_EXP[7]);
`else
    measure_chk("late2", W_EXP[1]);
`endif
    measure_chk("late2_next", W_EXP[1]);

    // Change in cycle P-3 is adopted at the next frame in either build.
    repeat (P - 4) step();
    posicao = 3'd3;
    wait_rise("late3");
    measure_chk("late3", W_EXP[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
